// File: rtl/cont_poller.sv
// Requester side of the controller link: launches contREAD periodically or on demand,
// waits for contWRITE with a timeout and holds the last good sample. Option: CONT_POLL_RETRY_EN.
module cont_poller #(
    parameter int DATA_W   = 8,
    parameter int POLL_DIV = 16666,
    parameter int TIMEOUT  = 255
) (
    input  logic              SYSCLK,
    input  logic              SYSRESET,
    input  logic              poll_en,
    input  logic              poll_req,
    output logic              contREAD,
    input  logic              contWRITE,
    input  logic [DATA_W-1:0] RDATA,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              changed,
    output logic              busy,
    output logic              timeout_err,
    output logic [7:0]        err_cnt
);

    localparam int DW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, TOUT} state_t;

    state_t            state, state_nxt;
    logic [DW-1:0]     div;
    logic [TW-1:0]     tcnt;
    logic              pending;
    logic              wrap;
    logic              launch;
    logic              capture;
    logic              report;
`ifdef CONT_POLL_RETRY_EN
    logic              retry;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wrap   = poll_en && (div == DIV_LAST);
    assign launch = (state == IDLE) && pending;

    always_comb begin
        state_nxt   = state;
        contREAD    = 1'b0;
        busy        = 1'b0;
        capture     = 1'b0;
        report      = 1'b0;
        case (state)
            IDLE: begin
                if (pending) state_nxt = REQ;
            end
            REQ: begin
                contREAD  = 1'b1;
                busy      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // A response on the final allowed cycle still wins over the timeout.
                if (contWRITE) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tcnt == TO_LAST) begin
                    state_nxt = TOUT;
                end
            end
            TOUT: begin
`ifdef CONT_POLL_RETRY_EN
                if (retry) begin
                    report    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REQ;
                end
`else
                report    = 1'b1;
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
        timeout_err = report;
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state      <= IDLE;
            div        <= '0;
            tcnt       <= '0;
            pending    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            changed    <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            state <= state_nxt;

            if (!poll_en || wrap) div <= '0;
            else                  div <= div + DW'(1);

            // Single-entry request latch: any number of requests collapse into one.
            pending <= (pending && !launch) || poll_req || wrap;

            if (state == REQ)       tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + TW'(1);

            changed <= capture && (!data_valid || (RDATA != data_out));
            if (capture) begin
                data_out   <= RDATA;
                data_valid <= 1'b1;
            end

            if (report) err_cnt <= sat_inc8(err_cnt);
        end
    end

`ifdef CONT_POLL_RETRY_EN
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET)                retry <= 1'b0;
        else if (capture || report)  retry <= 1'b0;
        else if (state == TOUT)      retry <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_cont_poller.sv
// Scoreboard bench for cont_poller: a controller model and the stimulus push expected
// transaction endings; a negedge monitor pops and compares them when busy falls.
module tb_cont_poller;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       chg;
        logic       tout;
        int         blen;
    } exp_t;

    logic       SYSCLK = 1'b0;
    logic       SYSRESET, rst_s;
    logic       poll_en, poll_req;
    logic       contREAD, contWRITE;
    logic [7:0] RDATA, data_out, err_cnt;
    logic       data_valid, changed, busy, timeout_err;

    logic       contREAD_s, busy_s, changed_s, data_valid_s, timeout_err_s;
    logic [7:0] data_out_s, err_cnt_s;
    logic       poll_en_s = 1'b1;
    logic       poll_req_s = 1'b0;
    logic       contWRITE_s = 1'b0;
    logic [7:0] RDATA_s = 8'h00;

    exp_t       exp_q[$];
    int         cr_times[$];
    int         cyc = 0;
    int         checks = 0, failures = 0;
    int         ev_cnt = 0, cr_cnt = 0, terr_cnt = 0, terr_s = 0, last_terr = 0;
    logic       resp_on = 1'b1;
    int         resp_dly = 2;
    logic [7:0] resp_data = 8'h00;
    int         spur_req = 0;
    logic [7:0] model_data;
    logic       model_valid;

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    cont_poller #(.DATA_W(8), .POLL_DIV(16), .TIMEOUT(255)) dut (
        .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .poll_en(poll_en), .poll_req(poll_req),
        .contREAD(contREAD), .contWRITE(contWRITE), .RDATA(RDATA), .data_out(data_out),
        .data_valid(data_valid), .changed(changed), .busy(busy),
        .timeout_err(timeout_err), .err_cnt(err_cnt));

    cont_poller #(.DATA_W(8), .POLL_DIV(4), .TIMEOUT(1)) dut_s (
        .SYSCLK(SYSCLK), .SYSRESET(rst_s), .poll_en(poll_en_s), .poll_req(poll_req_s),
        .contREAD(contREAD_s), .contWRITE(contWRITE_s), .RDATA(RDATA_s), .data_out(data_out_s),
        .data_valid(data_valid_s), .changed(changed_s), .busy(busy_s),
        .timeout_err(timeout_err_s), .err_cnt(err_cnt_s));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SYSCLK);
            #1;
        end
    endtask

    task automatic pulse_req();
        poll_req = 1'b1;
        tick(1);
        poll_req = 1'b0;
    endtask

    task automatic wait_ev(input int target, input int budget);
        int i = 0;
        while (ev_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        check("wait_event", ev_cnt, target);
    endtask

    task automatic wait_cr(input int target, input int budget);
        int i = 0;
        while (cr_cnt < target && i < budget) begin
            tick(1);
            i++;
        end
        check("wait_contread", cr_cnt, target);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic v, input logic c, input logic t, input int bl);
        exp_t e;
        e.data = d; e.valid = v; e.chg = c; e.tout = t; e.blen = bl;
        exp_q.push_back(e);
    endtask

    // Controller model: answers resp_dly cycles after contREAD and predicts the capture.
    initial begin
        int         cnt;
        int         pdly;
        int         spur_done;
        logic       ab;
        logic [7:0] pd;
        exp_t       e;
        cnt = 0; pdly = 0; spur_done = 0; ab = 1'b0; pd = 8'h00;
        contWRITE = 1'b0; RDATA = 8'h00; model_data = 8'h00; model_valid = 1'b0;
        forever begin
            @(posedge SYSCLK);
            if (SYSRESET) begin
                model_data = 8'h00;
                model_valid = 1'b0;
                if (cnt > 0) ab = 1'b1;
            end
            #1;
            contWRITE = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    contWRITE = 1'b1;
                    RDATA = pd;
                    if (!ab) begin
                        e.data = pd; e.valid = 1'b1; e.tout = 1'b0; e.blen = pdly + 1;
                        e.chg = !model_valid || (pd != model_data);
                        exp_q.push_back(e);
                        model_data = pd;
                        model_valid = 1'b1;
                    end
                    ab = 1'b0;
                end
            end else if (spur_req != spur_done) begin
                contWRITE = 1'b1;
                RDATA = 8'h77;
                spur_done++;
            end
            if (contREAD === 1'b1 && resp_on) begin
                cnt = resp_dly;
                pd = resp_data;
                pdly = resp_dly;
            end
        end
    end

    // Monitor: a transaction ends when busy falls.
    initial begin
        int   blen;
        logic pb;
        exp_t e;
        blen = 0; pb = 1'b0;
        forever begin
            @(negedge SYSCLK);
            if (contREAD === 1'b1) begin
                cr_times.push_back(cyc);
                cr_cnt++;
            end
            if (timeout_err === 1'b1) begin
                last_terr = cyc;
                terr_cnt++;
            end
            if (timeout_err_s === 1'b1) terr_s++;
            if (busy === 1'b1) blen++;
            if (pb && busy !== 1'b1) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ev_unexpected: data_out=%0h timeout_err=%0b, no entry expected", data_out, timeout_err);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_data_out", data_out, e.data);
                    check("ev_data_valid", data_valid, e.valid);
                    check("ev_changed", changed, e.chg);
                    check("ev_timeout_err", timeout_err, e.tout);
                    check("ev_busy_len", blen, e.blen);
                end
                blen = 0;
            end else if (changed !== 1'b0) begin
                check("changed_stray", changed, 1'b0);
            end
            pb = (busy === 1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, t_en, ev0, te0, i;
        SYSRESET = 1'b1; rst_s = 1'b1; poll_en = 1'b0; poll_req = 1'b0;
        tick(3);
        check("rst_contREAD", contREAD, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_changed", changed, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
        SYSRESET = 1'b0; rst_s = 1'b0;
        tick(2);

        // First capture, then same value, then a new value.
        resp_on = 1'b1; resp_dly = 2; resp_data = 8'hA5;
        base = cr_cnt;
        pulse_req();
        wait_ev(ev_cnt + 1, 30);
        check("t1_one_contread", cr_cnt - base, 1);
        tick(2);
        pulse_req();
        wait_ev(ev_cnt + 1, 30);
        tick(2);
        resp_data = 8'h3C;
        pulse_req();
        wait_ev(ev_cnt + 1, 30);
        check("t2_data_out", data_out, 8'h3C);

        // No response: timeout.
        tick(3);
        resp_on = 1'b0;
        base = cr_cnt;
`ifdef CONT_POLL_RETRY_EN
        push_exp(8'h3C, 1'b1, 1'b0, 1'b0, 256);
        push_exp(8'h3C, 1'b1, 1'b0, 1'b1, 256);
        pulse_req();
        wait_ev(ev_cnt + 2, 700);
        check("t3_retry_contreads", cr_cnt - base, 2);
        check("t3_timeout_latency", last_terr - cr_times[base], 513);
`else
        push_exp(8'h3C, 1'b1, 1'b0, 1'b1, 256);
        pulse_req();
        wait_ev(ev_cnt + 1, 400);
        check("t3_timeout_latency", last_terr - cr_times[base], 256);
`endif
        tick(2);
        check("t3_err_cnt", err_cnt, 8'd1);
        check("t3_data_hold", data_out, 8'h3C);

        // Response on the last allowed WAIT cycle counts as success.
        resp_on = 1'b1; resp_dly = 255; resp_data = 8'hC3;
        te0 = terr_cnt;
        pulse_req();
        wait_ev(ev_cnt + 1, 400);
        tick(2);
        check("t4_err_cnt", err_cnt, 8'd1);
        check("t4_no_timeout", terr_cnt - te0, 0);

        // Back-to-back requests: contREAD every 3 cycles.
        resp_dly = 1;
        base = cr_cnt;
        poll_req = 1'b1;
        tick(9);
        poll_req = 1'b0;
        wait_cr(base + 3, 20);
        tick(12);
        check("t5_gap1", cr_times[base + 1] - cr_times[base], 3);
        check("t5_gap2", cr_times[base + 2] - cr_times[base + 1], 3);

        // Requests during busy collapse into one.
        resp_dly = 3; resp_data = 8'h5A;
        base = cr_cnt;
        pulse_req();
        i = 0;
        while (contREAD !== 1'b1 && i < 10) begin
            tick(1);
            i++;
        end
        tick(1);
        poll_req = 1'b1;
        tick(2);
        poll_req = 1'b0;
        tick(30);
        check("t6_two_contreads", cr_cnt - base, 2);
        check("t6_gap", cr_times[base + 1] - cr_times[base], 5);

        // Periodic polling; poll_req on the wrap cycle is not an extra request.
        resp_dly = 1; resp_data = 8'h3C;
        base = cr_cnt;
        poll_en = 1'b1;
        t_en = cyc;
        tick(15);
        poll_req = 1'b1;
        tick(1);
        poll_req = 1'b0;
        wait_cr(base + 4, 100);
        poll_en = 1'b0;
        check("t7_first_ofs", cr_times[base] - t_en, 17);
        for (int k = 1; k < 4; k++)
            check("t7_period", cr_times[base + k] - cr_times[base + k - 1], 16);
        tick(20);

        // Spurious contWRITE while idle.
        ev0 = ev_cnt;
        spur_req++;
        tick(5);
        check("t8_spur_data", data_out, 8'h3C);
        check("t8_spur_no_event", ev_cnt, ev0);
        check("t8_spur_err_cnt", err_cnt, 8'd1);

        // Reset during WAIT with a late response.
        resp_dly = 2; resp_data = 8'hFF;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0, 2);
        pulse_req();
        i = 0;
        while (contREAD !== 1'b1 && i < 10) begin
            tick(1);
            i++;
        end
        tick(1);
        SYSRESET = 1'b1;
        tick(1);
        SYSRESET = 1'b0;
        check("t9_contREAD", contREAD, 1'b0);
        check("t9_busy", busy, 1'b0);
        tick(3);
        check("t9_data_out", data_out, 8'h00);
        check("t9_data_valid", data_valid, 1'b0);
        check("t9_changed", changed, 1'b0);
        check("t9_err_cnt", err_cnt, 8'h00);

        // Saturation on the TIMEOUT=1 instance.
        i = 0;
        while (terr_s < 300 && i < 8000) begin
            tick(1);
            i++;
        end
        check("t10_pulses_reached", terr_s >= 300, 1'b1);
        tick(2);
        check("t10_err_cnt_sat", err_cnt_s, 8'hFF);
        check("t10_no_capture", {data_valid_s, changed_s, data_out_s}, 10'h000);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
